// File: rtl/sha512_pkg.sv
`default_nettype none
// ============================================================================
// Package : sha512_pkg
// Brief   : Shared SHA-512 block-assembly types, constants and length helper.
// Revision: 1.0
// ============================================================================
package sha512_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_OUT  = 3'd2,
        S_PAD  = 3'd3,
        S_DONE = 3'd4
    } t_asm_state;

    typedef logic [1023:0] t_sha512_block;

    localparam logic [7:0] SHA512_PAD_BYTE    = 8'h80;
    localparam int         SHA512_LEN_OFFSET  = 112;
    localparam int         SHA512_BLOCK_BYTES = 128;

    // 128-bit big-endian message length in bits; L < 2^32 keeps bits above 34 zero.
    function automatic logic [127:0] sha512_len_field(input logic [31:0] len_bytes);
        return {93'd0, len_bytes, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha512_pad_mux.sv
`default_nettype none
// ============================================================================
// Module  : sha512_pad_mux
// Brief   : Per-line byte mask, 0x80 marker and length insertion (combinational).
// Revision: 1.0
// ============================================================================
module sha512_pad_mux
    import sha512_pkg::*;
(
    input  logic [511:0] line_data,
    input  logic [32:0]  line_base,
    input  logic [31:0]  msg_len,
    input  logic         ins_len,
    output logic [511:0] half_data,
    output logic [511:0] tail_data
);

    logic [32:0]  w_len_ext;
    logic [32:0]  w_tail_base;
    logic [127:0] w_len_field;

    assign w_len_ext   = {1'b0, msg_len};
    assign w_tail_base = line_base + 33'd64;
    assign w_len_field = sha512_len_field(msg_len);

    // Line byte j (little-endian in the line) lands at big-endian half byte j.
    genvar j;
    generate
        for (j = 0; j < 64; j++) begin : g_byte
            logic [32:0] w_off;
            logic [7:0]  w_byte;

            assign w_off = line_base + 33'(j);

            always_comb begin
                if (w_off < w_len_ext) begin
                    w_byte = line_data[8*j +: 8];
                end else if (w_off == w_len_ext) begin
                    w_byte = SHA512_PAD_BYTE;
                end else begin
                    w_byte = 8'h00;
                end
            end

            if (j >= SHA512_LEN_OFFSET - 64) begin : g_len
                assign half_data[511-8*j -: 8] =
                    ins_len ? w_len_field[127-8*(j-48) -: 8] : w_byte;
            end else begin : g_data
                assign half_data[511-8*j -: 8] = w_byte;
            end
        end
    endgenerate

    // Synthetic half following this line: only zeros, a possible marker and the length.
    assign tail_data = {(w_tail_base == w_len_ext) ? SHA512_PAD_BYTE : 8'h00,
                        376'd0, w_len_field};

endmodule
`default_nettype wire

// File: rtl/sha512_block_assembler.sv
`default_nettype none
// ============================================================================
// Module  : sha512_block_assembler
// Brief   : Packs 512-bit cache lines into padded 1024-bit SHA-512 blocks.
// Revision: 1.0
// ============================================================================
module sha512_block_assembler
    import sha512_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   msg_size,
    input  logic          line_valid,
    input  logic [511:0]  line_data,
    output logic          line_ready,
    output logic          blk_valid,
    output logic [1023:0] blk_data,
    output logic          blk_last,
    input  logic          blk_ready,
    output logic          busy,
    output logic          done
);

    t_asm_state    r_state;
    t_asm_state    w_state_nxt;
    logic [31:0]   r_len;
    logic [26:0]   r_line_cnt;
    logic          r_half;
    t_sha512_block r_blk;
    logic          r_last;

    logic [26:0]   w_n_lines;
    logic          w_lines_left;
    logic          w_final_line;
    logic          w_line_hs;
    logic [6:0]    w_tail_r;
    logic          w_len_fits;
    logic          w_ins_len;
    logic [32:0]   w_line_base;
    logic [511:0]  w_half_data;
    logic [511:0]  w_tail_data;
    t_sha512_block w_pad_block;

    assign w_n_lines    = {1'b0, r_len[31:6]} + 27'(|r_len[5:0]);
    assign w_lines_left = (r_line_cnt < w_n_lines);
    assign w_final_line = ((r_line_cnt + 27'd1) == w_n_lines);
    assign w_line_hs    = line_valid && line_ready;
    assign w_tail_r     = r_len[6:0];
    assign w_len_fits   = (w_tail_r != 7'd0) && (w_tail_r <= 7'(SHA512_LEN_OFFSET - 1));
    assign w_ins_len    = r_half && w_final_line && w_len_fits;
    assign w_line_base  = {r_line_cnt, 6'd0};

    // Block built without data: L=0, or the extra block when the length did not fit.
    assign w_pad_block  = {(w_tail_r == 7'd0) ? SHA512_PAD_BYTE : 8'h00,
                           888'd0, sha512_len_field(r_len)};

    sha512_pad_mux u_pad_mux (
        .line_data (line_data),
        .line_base (w_line_base),
        .msg_len   (r_len),
        .ins_len   (w_ins_len),
        .half_data (w_half_data),
        .tail_data (w_tail_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        line_ready  = 1'b0;
        blk_valid   = 1'b0;
        done        = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                line_ready = w_lines_left;
                if (!w_lines_left && !r_half) begin
                    w_state_nxt = S_OUT;
                end else if (w_line_hs && (r_half || w_final_line)) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    if (r_last) begin
                        w_state_nxt = S_DONE;
                    end else if (w_lines_left) begin
                        w_state_nxt = S_FILL;
                    end else begin
                        w_state_nxt = S_PAD;
                    end
                end
            end
            S_PAD: begin
                w_state_nxt = S_OUT;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len      <= 32'd0;
            r_line_cnt <= 27'd0;
            r_half     <= 1'b0;
            r_blk      <= '0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len      <= msg_size;
                        r_line_cnt <= 27'd0;
                        r_half     <= 1'b0;
                        r_last     <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (w_line_hs) begin
                        r_line_cnt <= r_line_cnt + 27'd1;
                        r_half     <= ~r_half;
                        if (!r_half) begin
                            r_blk[1023:512] <= w_half_data;
                            // A final line in the first half always leaves room for the length.
                            if (w_final_line) begin
                                r_blk[511:0] <= w_tail_data;
                                r_last       <= 1'b1;
                            end
                        end else begin
                            r_blk[511:0] <= w_half_data;
                            r_last       <= w_ins_len;
                        end
                    end else if (!w_lines_left && !r_half) begin
                        r_blk  <= w_pad_block;
                        r_last <= 1'b1;
                    end
                end
                S_PAD: begin
                    r_blk  <= w_pad_block;
                    r_last <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign blk_data = r_blk;
    assign blk_last = r_last;

endmodule
`default_nettype wire
